// File: rtl/div_pkg.sv
// Shared sizing and FSM state encoding for the sequential restoring divider.
package div_pkg;

  localparam int DIV_N = 8;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_width(DIV_N);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    SUB   = 3'd3,
    FIX   = 3'd4,
    DONE  = 3'd5
  } div_state_e;

endpackage

// File: rtl/div_controller.sv
// Divider control FSM: sequences capture, load, shift/subtract iterations,
// sign fix-up and the done pulse; emits one strobe per datapath action.
module div_controller
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic divisor_zero,
  input  logic t_neg,
  input  logic count_zero,
  output logic cap,
  output logic ld,
  output logic sft,
  output logic sub_ld,
  output logic dec,
  output logic fix,
  output logic busy,
  output logic done
);

  div_state_e state_q, state_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    ld      = 1'b0;
    sft     = 1'b0;
    sub_ld  = 1'b0;
    dec     = 1'b0;
    fix     = 1'b0;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cap     = 1'b1;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      // A zero divisor detours through FIX so both paths share its cycle;
      // FIX then leaves the divide-by-zero results written by LOAD intact.
      LOAD: begin
        ld      = 1'b1;
        state_d = divisor_zero ? FIX : SHIFT;
      end
      SHIFT: begin
        sft     = 1'b1;
        state_d = SUB;
      end
      SUB: begin
        dec     = 1'b1;
        sub_ld  = ~t_neg;
        state_d = count_zero ? FIX : SHIFT;
      end
      FIX: begin
        fix     = ~divisor_zero;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider: magnitude A/Q/M datapath with a
// truncating sign fix-up, driven by div_controller.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int            CW       = cnt_width(N);
  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  // Unsigned magnitude; the most negative value maps to 2^(N-1) exactly.
  function automatic logic [N-1:0] mag(input logic [N-1:0] x);
    mag = x[N-1] ? (-x) : x;
  endfunction

  logic [N-1:0]  dvd_q, dvd_d, dvs_q, dvs_d;
  logic [N:0]    a_q, a_d, m_q, m_d;
  logic [N-1:0]  qr_q, qr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sgnq_q, sgnq_d, sgnr_q, sgnr_d;
  logic [N-1:0]  quo_q, quo_d, rem_q, rem_d;
  logic          dz_q, dz_d;

  logic [N:0] t_diff;
  logic       t_neg, divisor_zero, count_zero;
  logic       cap, ld, sft, sub_ld, dec, fix;

  assign t_diff       = a_q - m_q;
  assign t_neg        = t_diff[N];
  assign divisor_zero = (dvs_q == {N{1'b0}});
  assign count_zero   = (cnt_q == CNT_ONE);

  div_controller u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .divisor_zero (divisor_zero),
    .t_neg        (t_neg),
    .count_zero   (count_zero),
    .cap          (cap),
    .ld           (ld),
    .sft          (sft),
    .sub_ld       (sub_ld),
    .dec          (dec),
    .fix          (fix),
    .busy         (busy),
    .done         (done)
  );

  // Datapath next-state; the strobes are one-hot per controller state.
  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    a_d    = a_q;
    m_d    = m_q;
    qr_d   = qr_q;
    cnt_d  = cnt_q;
    sgnq_d = sgnq_q;
    sgnr_d = sgnr_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dz_d   = dz_q;
    if (cap) begin
      dvd_d = dividend;
      dvs_d = divisor;
    end else if (ld) begin
      a_d    = {(N+1){1'b0}};
      m_d    = {1'b0, mag(dvs_q)};
      qr_d   = mag(dvd_q);
      cnt_d  = CNT_INIT;
      sgnq_d = dvd_q[N-1] ^ dvs_q[N-1];
      sgnr_d = dvd_q[N-1];
      if (divisor_zero) begin
        quo_d = {N{1'b1}};
        rem_d = dvd_q;
        dz_d  = 1'b1;
      end else begin
        dz_d  = 1'b0;
      end
    end else if (sft) begin
      {a_d, qr_d} = {a_q, qr_q} << 1'b1;
    end else if (dec) begin
      if (sub_ld) begin
        a_d = t_diff;
      end else begin
        a_d = a_q;
      end
      qr_d[0] = ~t_neg;
      cnt_d   = cnt_q - CNT_ONE;
    end else if (fix) begin
      quo_d = sgnq_q ? (-qr_q) : qr_q;
      rem_d = sgnr_q ? (-a_q[N-1:0]) : a_q[N-1:0];
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= {N{1'b0}};
      dvs_q  <= {N{1'b0}};
      a_q    <= {(N+1){1'b0}};
      m_q    <= {(N+1){1'b0}};
      qr_q   <= {N{1'b0}};
      cnt_q  <= {CW{1'b0}};
      sgnq_q <= 1'b0;
      sgnr_q <= 1'b0;
      quo_q  <= {N{1'b0}};
      rem_q  <= {N{1'b0}};
      dz_q   <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      a_q    <= a_d;
      m_q    <= m_d;
      qr_q   <= qr_d;
      cnt_q  <= cnt_d;
      sgnq_q <= sgnq_d;
      sgnr_q <= sgnr_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dz_q   <= dz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (N=8).
module tb_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int base_cnt = 0;

  seq_divider #(.N(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start is high across exactly one rising edge (edge 0); returns just after it.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Launch, then check done timing at interval lat and the results held there.
  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eq, input logic [7:0] er, input logic edz,
                     input int lat);
    launch(a, b);
    repeat (lat) @(negedge clk);
    chk1({tag, "_done_early"}, done, 1'b0);
    @(negedge clk);
    chk1({tag, "_done"}, done, 1'b1);
    chk8({tag, "_quo"}, quotient, eq);
    chk8({tag, "_rem"}, remainder, er);
    chk1({tag, "_dz"}, div_by_zero, edz);
    @(negedge clk);
    chk1({tag, "_done_after"}, done, 1'b0);
    chk1({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 8'h00;
    repeat (2) @(negedge clk);
    chk8("rst_quo", quotient, 8'h00);
    chk8("rst_rem", remainder, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_dz", div_by_zero, 1'b0);
    rst_n = 1'b1;

    // 100/7 with cycle-accurate busy/done profile
    launch(8'd100, 8'd7);
    for (int e = 0; e <= 19; e++) begin
      @(negedge clk);
      chk1($sformatf("p100_7_busy_e%0d", e), busy, (e <= 18));
      chk1($sformatf("p100_7_done_e%0d", e), done, (e == 18));
      if (e == 18) begin
        chk8("p100_7_quo", quotient, 8'd14);
        chk8("p100_7_rem", remainder, 8'd2);
        chk1("p100_7_dz", div_by_zero, 1'b0);
      end
    end

    run("n100_7", 8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0, 18);
    run("p100_n7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 18);
    run("p5_0",   8'd5,  8'h00, 8'hFF, 8'h05, 1'b1, 2);
    run("n128_n1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 18);
    run("p3_9",   8'd3,  8'd9,  8'h00, 8'h03, 1'b0, 18);

    // second start at edge 5 with other operands must be ignored
    launch(8'd100, 8'd7);
    base_cnt = done_cnt;
    repeat (5) @(negedge clk);
    dividend = 8'd20;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(negedge clk);
    chk1("busy_start_done", done, 1'b1);
    chk8("busy_start_quo", quotient, 8'd14);
    chk8("busy_start_rem", remainder, 8'd2);
    repeat (20) @(negedge clk);
    #2 chk32("busy_start_pulses", done_cnt - base_cnt, 1);

    // back-to-back: second start in the first IDLE cycle after done
    launch(8'd100, 8'd7);
    repeat (19) @(negedge clk);
    chk1("b2b_first_done", done, 1'b1);
    chk8("b2b_first_quo", quotient, 8'd14);
    @(negedge clk);
    chk1("b2b_idle_busy", busy, 1'b0);
    dividend = 8'hF9;
    divisor  = 8'd2;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (18) @(negedge clk);
    chk8("b2b_hold_quo", quotient, 8'd14);
    chk8("b2b_hold_rem", remainder, 8'd2);
    chk1("b2b_hold_busy", busy, 1'b1);
    @(negedge clk);
    chk1("b2b_second_done", done, 1'b1);
    chk8("b2b_second_quo", quotient, 8'hFD);
    chk8("b2b_second_rem", remainder, 8'hFF);
    @(negedge clk);
    chk1("b2b_second_idle", busy, 1'b0);

    // reset at edge 9 of an operation aborts it with no done
    launch(8'd77, 8'd3);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk8("midrst_quo", quotient, 8'h00);
    chk8("midrst_rem", remainder, 8'h00);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk1("midrst_dz", div_by_zero, 1'b0);
    base_cnt = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    #2 chk32("midrst_no_done", done_cnt - base_cnt, 0);
    run("p50_5", 8'd50, 8'd5, 8'd10, 8'h00, 1'b0, 18);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
